trap_ctrl: RTL and testbench

- Sits directly upstream of the CSR file; it is the block that produces the CSR's trap-entry strobe, cause and exception PC.
- Arbitrates between decode-stage ecall, mret and the UART interrupt line, and owns the pending-interrupt latch.
- Sequences trap entry: flush the pipeline, pulse the CSR capture, redirect fetch to mtvec. Sequences trap return by redirecting fetch to mepc.

---
 rtl/trap_ctrl_if.sv | 36 +++
 rtl/trap_ctrl.sv | 156 +++++++++++++++
 tb/tb_trap_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// Pipeline/CSR-facing signal bundle for the trap controller.
// The slave side is the trap controller; the master side is the pipeline/CSR environment.
interface trap_ctrl_if #(
    parameter int XLEN = 32
) ();
    logic            ecall;
    logic            mret;
    logic            stall;
    logic            uart_IRQ;
    logic            mstatus_mie;
    logic            mie_meie;
    logic [XLEN-1:0] IF_ID_pres_addr;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic            flush;
    logic            trigger_trap;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_epc;
    logic            pc_redirect;
    logic [XLEN-1:0] pc_redirect_addr;
    logic            trapping;

    modport slave (
        input  ecall, mret, stall, uart_IRQ, mstatus_mie, mie_meie,
        input  IF_ID_pres_addr, mtvec, mepc,
        output flush, trigger_trap, trap_cause, trap_epc,
        output pc_redirect, pc_redirect_addr, trapping
    );

    modport master (
        output ecall, mret, stall, uart_IRQ, mstatus_mie, mie_meie,
        output IF_ID_pres_addr, mtvec, mepc,
        input  flush, trigger_trap, trap_cause, trap_epc,
        input  pc_redirect, pc_redirect_addr, trapping
    );
endinterface

// File: rtl/trap_ctrl.sv
// Trap controller: arbitrates ecall / UART interrupt, sequences trap entry
// (flush, CSR capture strobe, redirect to mtvec) and trap return (redirect to mepc).
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | normal execution, watching for ecall or an enabled pending IRQ
// FLUSH   | pipeline flush held for FLUSH_CYCLES cycles
// ENTER   | one-cycle CSR capture strobe and redirect to the trap vector
// HANDLER | running the handler, waiting for an unstalled mret
// RETURN  | one-cycle redirect to mepc with flush
module trap_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int XLEN         = 32
) (
    input  logic        clk,
    input  logic        Rst,
    trap_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FLUSH   = 3'd1,
        ENTER   = 3'd2,
        HANDLER = 3'd3,
        RETURN  = 3'd4
    } state_t;

    localparam logic [3:0]      FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [XLEN-1:0] CAUSE_ECALL = XLEN'(11);
    localparam logic [XLEN-1:0] CAUSE_IRQ   = {1'b1, {(XLEN-1){1'b0}}} | XLEN'(11);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] redir_addr_q, redir_addr_d;
    logic            irq_prev_q;
    logic            irq_pending_q;
    logic            flush_q, trig_q, redir_q, trapping_q;

    logic            irq_enabled;
    logic            irq_edge;
    logic            ecall_take;
    logic            irq_take;
    logic [XLEN-1:0] tvec_base;
    logic [XLEN-1:0] tvec_target;

    // Low address bits of mtvec/mepc never reach the redirect target.
    wire unused_bits = &{1'b0, bus.mtvec[1], bus.mepc[1:0]};

    assign irq_enabled = bus.mstatus_mie & bus.mie_meie;
    assign irq_edge    = bus.uart_IRQ & ~irq_prev_q;
    assign ecall_take  = (state_q == IDLE) & bus.ecall & ~bus.stall;
    // ecall wins a simultaneous request; the interrupt simply stays latched.
    assign irq_take    = (state_q == IDLE) & ~ecall_take & irq_pending_q & irq_enabled;

    // Vectored mode only applies to interrupt causes; exceptions use the base.
    assign tvec_base   = {bus.mtvec[XLEN-1:2], 2'b00};
    assign tvec_target = (bus.mtvec[0] & cause_q[XLEN-1])
                         ? tvec_base + {cause_q[XLEN-3:0], 2'b00}
                         : tvec_base;

    // State register.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state, counter, capture and redirect-target logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cause_d      = cause_q;
        epc_d        = epc_q;
        redir_addr_d = '0;
        case (state_q)
            IDLE: begin
                if (ecall_take || irq_take) begin
                    cause_d = ecall_take ? CAUSE_ECALL : CAUSE_IRQ;
                    epc_d   = bus.IF_ID_pres_addr;
                    cnt_d   = FLUSH_LOAD;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (cnt_q == 4'd0) begin
                    state_d      = ENTER;
                    redir_addr_d = tvec_target;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ENTER: begin
                state_d = HANDLER;
            end
            HANDLER: begin
                if (bus.mret && !bus.stall) begin
                    state_d      = RETURN;
                    redir_addr_d = {bus.mepc[XLEN-1:2], 2'b00};
                end
            end
            RETURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Counter, captured cause/epc and registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            cnt_q        <= '0;
            cause_q      <= '0;
            epc_q        <= '0;
            redir_addr_q <= '0;
            flush_q      <= 1'b0;
            trig_q       <= 1'b0;
            redir_q      <= 1'b0;
            trapping_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            cause_q      <= cause_d;
            epc_q        <= epc_d;
            redir_addr_q <= redir_addr_d;
            flush_q      <= (state_d == FLUSH) || (state_d == RETURN);
            trig_q       <= (state_d == ENTER);
            redir_q      <= (state_d == ENTER) || (state_d == RETURN);
            trapping_q   <= (state_d == FLUSH) || (state_d == ENTER) || (state_d == HANDLER);
        end
    end

    // Interrupt edge detect and pending latch; acceptance clears it.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            irq_prev_q    <= 1'b0;
            irq_pending_q <= 1'b0;
        end else begin
            irq_prev_q <= bus.uart_IRQ;
            if (irq_take)
                irq_pending_q <= 1'b0;
            else if (irq_edge && irq_enabled)
                irq_pending_q <= 1'b1;
        end
    end

    assign bus.flush            = flush_q;
    assign bus.trigger_trap     = trig_q;
    assign bus.trap_cause       = cause_q;
    assign bus.trap_epc         = epc_q;
    assign bus.pc_redirect      = redir_q;
    assign bus.pc_redirect_addr = redir_addr_q;
    assign bus.trapping         = trapping_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: expected trap entries/returns are queued when
// stimulus is driven and compared whenever the DUT redirects fetch.
module tb_trap_ctrl;

    localparam int FC   = 2;
    localparam int XLEN = 32;

    typedef struct {
        bit          is_ret;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] addr;
        int          cyc;
    } ev_t;

    logic clk;
    logic Rst;
    int   cyc;
    int   n_tests;
    int   n_fail;
    int   flush_run;
    ev_t  q[$];

    trap_ctrl_if #(.XLEN(XLEN)) bus ();

    trap_ctrl #(.FLUSH_CYCLES(FC), .XLEN(XLEN)) dut (
        .clk (clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_enter(input logic [31:0] cause, input logic [31:0] epc,
                              input logic [31:0] addr, input int c);
        ev_t e;
        e.is_ret = 1'b0; e.cause = cause; e.epc = epc; e.addr = addr; e.cyc = c;
        q.push_back(e);
    endtask

    task automatic push_ret(input logic [31:0] addr, input int c);
        ev_t e;
        e.is_ret = 1'b1; e.cause = '0; e.epc = '0; e.addr = addr; e.cyc = c;
        q.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            step(1);
            n++;
        end
        check("drain_timeout", q.size(), 0);
    endtask

    // Output monitor: every redirect must match the head of the scoreboard.
    always @(negedge clk) begin
        ev_t e;
        if (bus.pc_redirect) begin
            if (q.size() == 0) begin
                check("unexp_redirect", {31'd0, bus.pc_redirect}, 32'd0);
            end else begin
                e = q.pop_front();
                check("trig_kind", {31'd0, bus.trigger_trap}, {31'd0, ~e.is_ret});
                check("redir_addr", bus.pc_redirect_addr, e.addr);
                if (e.cyc >= 0) check("redir_cycle", cyc, e.cyc);
                if (!e.is_ret) begin
                    check("cause", bus.trap_cause, e.cause);
                    check("epc", bus.trap_epc, e.epc);
                    check("flush_len", flush_run, FC);
                    check("enter_flush", {31'd0, bus.flush}, 32'd0);
                    check("enter_trapping", {31'd0, bus.trapping}, 32'd1);
                end else begin
                    check("ret_flush", {31'd0, bus.flush}, 32'd1);
                    check("ret_trapping", {31'd0, bus.trapping}, 32'd0);
                end
            end
        end else begin
            check("trig_no_redir", {31'd0, bus.trigger_trap}, 32'd0);
            check("addr_idle", bus.pc_redirect_addr, 32'd0);
        end
        flush_run = (bus.flush && !bus.pc_redirect) ? flush_run + 1 : 0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int m;
        cyc = 0; n_tests = 0; n_fail = 0; flush_run = 0;
        Rst = 1'b0;
        bus.ecall = 0; bus.mret = 0; bus.stall = 0; bus.uart_IRQ = 0;
        bus.mstatus_mie = 1; bus.mie_meie = 1;
        bus.IF_ID_pres_addr = 32'h100; bus.mtvec = 32'h400; bus.mepc = 32'h0;
        #2;
        check("rst_flush", {31'd0, bus.flush}, 32'd0);
        check("rst_trig", {31'd0, bus.trigger_trap}, 32'd0);
        check("rst_redir", {31'd0, bus.pc_redirect}, 32'd0);
        check("rst_trapping", {31'd0, bus.trapping}, 32'd0);
        check("rst_cause", bus.trap_cause, 32'd0);
        check("rst_epc", bus.trap_epc, 32'd0);
        step(3);
        Rst = 1'b1;
        step(2);

        // Plain ecall with latency check.
        bus.IF_ID_pres_addr = 32'h100; bus.mtvec = 32'h400;
        bus.ecall = 1;
        push_enter(32'h0000_000B, 32'h100, 32'h400, cyc + FC + 1);
        step(1);
        bus.ecall = 0;
        check("flush_n1", {31'd0, bus.flush}, 32'd1);
        drain(20);
        step(1);
        check("handler_trapping", {31'd0, bus.trapping}, 32'd1);
        check("cause_hold", bus.trap_cause, 32'h0000_000B);
        bus.mepc = 32'h200; bus.mret = 1;
        push_ret(32'h200, cyc + 1);
        step(1);
        bus.mret = 0;
        drain(10);
        step(2);

        // UART interrupt, vectored mtvec.
        bus.IF_ID_pres_addr = 32'h2C; bus.mtvec = 32'h401;
        bus.uart_IRQ = 1;
        push_enter(32'h8000_000B, 32'h2C, 32'h42C, -1);
        drain(20);
        step(2);
        bus.mepc = 32'h303; bus.mret = 1;
        push_ret(32'h300, cyc + 1);
        step(1);
        bus.mret = 0;
        drain(10);
        bus.uart_IRQ = 0;
        step(3);
        check("no_retrigger", {31'd0, bus.trapping}, 32'd0);

        // ecall and IRQ edge together: ecall first, IRQ right after mret.
        bus.IF_ID_pres_addr = 32'h100; bus.mtvec = 32'h400;
        bus.ecall = 1; bus.uart_IRQ = 1;
        push_enter(32'h0000_000B, 32'h100, 32'h400, cyc + FC + 1);
        step(1);
        bus.ecall = 0;
        drain(20);
        bus.IF_ID_pres_addr = 32'h108;
        step(2);
        bus.mepc = 32'h104; bus.mret = 1;
        m = cyc;
        push_ret(32'h104, m + 1);
        push_enter(32'h8000_000B, 32'h108, 32'h400, m + FC + 3);
        step(1);
        bus.mret = 0;
        drain(20);
        step(1);
        bus.mepc = 32'h10C; bus.mret = 1;
        push_ret(32'h10C, cyc + 1);
        step(1);
        bus.mret = 0;
        drain(10);
        bus.uart_IRQ = 0;
        step(2);

        // Edge with interrupts globally disabled is dropped; later edge is taken.
        bus.mstatus_mie = 0;
        bus.uart_IRQ = 1;
        step(3);
        bus.uart_IRQ = 0;
        step(1);
        bus.mstatus_mie = 1;
        step(6);
        check("masked_edge", {31'd0, bus.trapping}, 32'd0);
        bus.IF_ID_pres_addr = 32'h50; bus.mtvec = 32'h401;
        bus.uart_IRQ = 1;
        push_enter(32'h8000_000B, 32'h50, 32'h42C, -1);
        drain(20);
        step(1);
        bus.mepc = 32'h54; bus.mret = 1;
        push_ret(32'h54, cyc + 1);
        step(1);
        bus.mret = 0;
        drain(10);
        bus.uart_IRQ = 0;
        step(2);

        // Stalled ecall and mret in IDLE are ignored.
        bus.ecall = 1; bus.stall = 1;
        step(2);
        bus.ecall = 0; bus.stall = 0;
        step(4);
        check("stalled_ecall", {31'd0, bus.trapping}, 32'd0);
        bus.mret = 1;
        step(1);
        bus.mret = 0;
        step(3);
        check("idle_mret", {31'd0, bus.trapping}, 32'd0);

        // ecall inside the handler is ignored.
        bus.IF_ID_pres_addr = 32'h80; bus.mtvec = 32'h402;
        bus.ecall = 1;
        push_enter(32'h0000_000B, 32'h80, 32'h400, cyc + FC + 1);
        step(1);
        drain(20);
        step(4);
        bus.ecall = 0;
        check("handler_ecall", {31'd0, bus.trapping}, 32'd1);
        check("handler_epc", bus.trap_epc, 32'h80);
        bus.mepc = 32'h84; bus.mret = 1;
        push_ret(32'h84, cyc + 1);
        step(1);
        bus.mret = 0;
        drain(10);
        step(2);

        // Reset during FLUSH abandons the trap.
        bus.IF_ID_pres_addr = 32'h100; bus.mtvec = 32'h400;
        bus.ecall = 1;
        step(1);
        bus.ecall = 0;
        check("pre_rst_flush", {31'd0, bus.flush}, 32'd1);
        #2;
        Rst = 1'b0;
        #1;
        check("midrst_flush", {31'd0, bus.flush}, 32'd0);
        check("midrst_trapping", {31'd0, bus.trapping}, 32'd0);
        check("midrst_cause", bus.trap_cause, 32'd0);
        step(3);
        check("midrst_trig", {31'd0, bus.trigger_trap}, 32'd0);
        Rst = 1'b1;
        step(2);
        bus.IF_ID_pres_addr = 32'h120;
        bus.ecall = 1;
        push_enter(32'h0000_000B, 32'h120, 32'h400, cyc + FC + 1);
        step(1);
        bus.ecall = 0;
        drain(20);
        step(1);
        bus.mepc = 32'h124; bus.mret = 1;
        push_ret(32'h124, cyc + 1);
        step(1);
        bus.mret = 0;
        drain(10);
        step(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
